// File: rtl/run_length_tracker_pkg.sv
// Shared types and default widths for the run-length tracker.
// Optional over-threshold counting is enabled by defining RUN_TRACKER_OVER_COUNT_EN.
package run_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SAT  = 2'd2
  } run_state_t;

  localparam int DEF_CNT_W = 8;
  localparam int DEF_OVR_W = 16;

endpackage

// File: rtl/run_length_tracker_if.sv
// Stream/statistics bundle of the run-length tracker.
// Sampling contract: i_data, i_mode and i_clear are taken on a rising clock edge
// only when i_ENABLE is 1 (i_clear also acts while i_ENABLE is 0); the statistics
// outputs change only on rising edges, and o_run_done is a single-cycle pulse.
interface run_length_tracker_if
  import run_tracker_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int OVR_W = DEF_OVR_W
);

  logic             i_ENABLE;
  logic             i_data;
  logic             i_mode;
  logic             i_clear;
  logic [CNT_W-1:0] i_threshold;
  logic [CNT_W-1:0] o_current;
  logic [CNT_W-1:0] o_max;
  logic [CNT_W-1:0] o_last_len;
  logic             o_run_done;
  logic             o_saturated;
  logic [OVR_W-1:0] o_over_count;
  run_state_t       dbg_state;

  modport master (
    output i_ENABLE, i_data, i_mode, i_clear, i_threshold,
    input  o_current, o_max, o_last_len, o_run_done, o_saturated, o_over_count,
    input  dbg_state
  );

  modport slave (
    input  i_ENABLE, i_data, i_mode, i_clear, i_threshold,
    output o_current, o_max, o_last_len, o_run_done, o_saturated, o_over_count,
    output dbg_state
  );

endinterface

// File: rtl/run_length_tracker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_NOT_RESET,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  assign sat = (count == {WIDTH{1'b1}});

  always_ff @(posedge i_clk or negedge i_NOT_RESET) begin
    if (!i_NOT_RESET) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/run_length_tracker.sv
// Run-length statistics over a qualified bit stream: current, max, last run, end pulse.
// Define RUN_TRACKER_OVER_COUNT_EN to build the over-threshold run counter.
module run_length_tracker
  import run_tracker_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int OVR_W = DEF_OVR_W
) (
  input logic                 i_clk,
  input logic                 i_NOT_RESET,
  run_length_tracker_if.slave bus
);

  localparam logic [CNT_W-1:0] RUN_MAX = {CNT_W{1'b1}};

  run_state_t       state;
  run_state_t       state_nxt;
  logic             match;
  logic             cur_inc;
  logic             cur_clr;
  logic             cur_sat;
  logic             run_end;
  logic [CNT_W-1:0] cur;
  logic [CNT_W-1:0] cur_nxt_val;
  logic [CNT_W-1:0] max_q;
  logic [CNT_W-1:0] last_q;
  logic             done_q;
  logic [OVR_W-1:0] over_q;

  assign match       = (bus.i_data == bus.i_mode);
  assign cur_nxt_val = cur_sat ? cur : cur + CNT_W'(1);

  // State register
  always_ff @(posedge i_clk or negedge i_NOT_RESET) begin
    if (!i_NOT_RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the same length test also covers the 1-bit case where
  // the first matching sample already reaches RUN_MAX.
  always_comb begin
    state_nxt = state;
    if (bus.i_clear) begin
      state_nxt = ST_IDLE;
    end else if (bus.i_ENABLE) begin
      case (state)
        ST_IDLE: begin
          if (match) state_nxt = (cur_nxt_val == RUN_MAX) ? ST_SAT : ST_RUN;
        end
        ST_RUN, ST_SAT: begin
          if (match) state_nxt = (cur_nxt_val == RUN_MAX) ? ST_SAT : ST_RUN;
          else       state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output/control logic
  always_comb begin
    run_end = 1'b0;
    cur_inc = 1'b0;
    cur_clr = 1'b0;
    if (!bus.i_clear && bus.i_ENABLE) begin
      run_end = !match && (state != ST_IDLE);
      cur_inc = match;
    end
    cur_clr = bus.i_clear || run_end;
  end

  sat_counter #(.WIDTH(CNT_W)) u_cur (
    .i_clk       (i_clk),
    .i_NOT_RESET (i_NOT_RESET),
    .clr         (cur_clr),
    .inc         (cur_inc),
    .count       (cur),
    .sat         (cur_sat)
  );

  // Statistics registers; a clear on the same edge as a run end swallows it.
  always_ff @(posedge i_clk or negedge i_NOT_RESET) begin
    if (!i_NOT_RESET) begin
      max_q  <= '0;
      last_q <= '0;
      done_q <= 1'b0;
    end else if (bus.i_clear) begin
      max_q  <= '0;
      last_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= run_end;
      if (run_end) last_q <= cur;
      if (cur_inc && (cur_nxt_val > max_q)) max_q <= cur_nxt_val;
    end
  end

`ifdef RUN_TRACKER_OVER_COUNT_EN
  logic ovr_inc;
  logic ovr_unused_sat;

  assign ovr_inc = run_end && (bus.i_threshold != '0) && (cur >= bus.i_threshold);

  sat_counter #(.WIDTH(OVR_W)) u_over (
    .i_clk       (i_clk),
    .i_NOT_RESET (i_NOT_RESET),
    .clr         (bus.i_clear),
    .inc         (ovr_inc),
    .count       (over_q),
    .sat         (ovr_unused_sat)
  );
`else
  logic thr_unused;

  assign thr_unused = ^bus.i_threshold;
  assign over_q     = '0;
`endif

  assign bus.o_current    = cur;
  assign bus.o_max        = max_q;
  assign bus.o_last_len   = last_q;
  assign bus.o_run_done   = done_q;
  assign bus.o_saturated  = (state == ST_SAT);
  assign bus.o_over_count = over_q;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_run_length_tracker.sv
// Directed self-checking bench for run_length_tracker (CNT_W=4 so saturation is short).
module tb_run_length_tracker;
  import run_tracker_pkg::*;

  localparam int CNT_W = 4;
  localparam int OVR_W = 16;

  logic i_clk;
  logic i_NOT_RESET;
  int   n_cmp;
  int   n_err;
  int   exp_over2;
  int   exp_over1;

  run_length_tracker_if #(.CNT_W(CNT_W), .OVR_W(OVR_W)) bus ();

  run_length_tracker #(.CNT_W(CNT_W), .OVR_W(OVR_W)) dut (
    .i_clk       (i_clk),
    .i_NOT_RESET (i_NOT_RESET),
    .bus         (bus)
  );

  // Clock
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic d, input logic clr);
    bus.i_ENABLE = en;
    bus.i_data   = d;
    bus.i_clear  = clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic run_of(input int n);
    for (int i = 0; i < n; i++) step(1'b1, bus.i_mode, 1'b0);
    step(1'b1, ~bus.i_mode, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
`ifdef RUN_TRACKER_OVER_COUNT_EN
    exp_over1 = 1;
    exp_over2 = 2;
`else
    exp_over1 = 0;
    exp_over2 = 0;
`endif
    i_NOT_RESET     = 1'b0;
    bus.i_ENABLE    = 1'b0;
    bus.i_data      = 1'b0;
    bus.i_mode      = 1'b0;
    bus.i_clear     = 1'b0;
    bus.i_threshold = '0;

    // Reset state
    #12;
    chk("rst_current", 32'(bus.o_current), 0);
    chk("rst_max", 32'(bus.o_max), 0);
    chk("rst_last", 32'(bus.o_last_len), 0);
    chk("rst_done", 32'(bus.o_run_done), 0);
    chk("rst_sat", 32'(bus.o_saturated), 0);
    chk("rst_over", 32'(bus.o_over_count), 0);
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(negedge i_clk);
    i_NOT_RESET = 1'b1;

    // Zero runs: data 1,0,0,0,1
    step(1, 1, 0); chk("z_cur0", 32'(bus.o_current), 0); chk("z_done0", 32'(bus.o_run_done), 0);
    step(1, 0, 0); chk("z_cur1", 32'(bus.o_current), 1); chk("z_state_run", 32'(bus.dbg_state), 32'(ST_RUN));
    step(1, 0, 0); chk("z_cur2", 32'(bus.o_current), 2); chk("z_done2", 32'(bus.o_run_done), 0);
    step(1, 0, 0); chk("z_cur3", 32'(bus.o_current), 3); chk("z_max3", 32'(bus.o_max), 3);
    step(1, 1, 0);
    chk("z_end_cur", 32'(bus.o_current), 0);
    chk("z_end_done", 32'(bus.o_run_done), 1);
    chk("z_end_last", 32'(bus.o_last_len), 3);
    chk("z_end_max", 32'(bus.o_max), 3);
    chk("z_end_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    chk("z_over_thr0", 32'(bus.o_over_count), 0);
    step(1, 1, 0); chk("z_done_drop", 32'(bus.o_run_done), 0);

    // Clear, then ones mode with an enable gap
    step(1, 0, 1);
    chk("clr_cur", 32'(bus.o_current), 0);
    chk("clr_max", 32'(bus.o_max), 0);
    chk("clr_last", 32'(bus.o_last_len), 0);
    bus.i_mode = 1'b1;
    step(1, 1, 0); chk("o_cur1", 32'(bus.o_current), 1);
    step(1, 1, 0); chk("o_cur2", 32'(bus.o_current), 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("o_gap_cur", 32'(bus.o_current), 2);
      chk("o_gap_done", 32'(bus.o_run_done), 0);
    end
    step(1, 1, 0); chk("o_cur3", 32'(bus.o_current), 3); chk("o_done_pre", 32'(bus.o_run_done), 0);
    step(1, 0, 0);
    chk("o_end_cur", 32'(bus.o_current), 0);
    chk("o_end_done", 32'(bus.o_run_done), 1);
    chk("o_end_last", 32'(bus.o_last_len), 3);
    chk("o_end_max", 32'(bus.o_max), 3);
    step(0, 0, 0); chk("o_done_drop_gap", 32'(bus.o_run_done), 0);

    // Saturation: 20 ones, RUN_MAX = 15
    step(1, 0, 1);
    for (int k = 1; k <= 20; k++) begin
      step(1, 1, 0);
      chk("s_cur", 32'(bus.o_current), (k < 15) ? k : 15);
      chk("s_sat", 32'(bus.o_saturated), (k >= 15) ? 1 : 0);
    end
    chk("s_max", 32'(bus.o_max), 15);
    chk("s_state", 32'(bus.dbg_state), 32'(ST_SAT));
    step(1, 0, 0);
    chk("s_end_cur", 32'(bus.o_current), 0);
    chk("s_end_last", 32'(bus.o_last_len), 15);
    chk("s_end_sat", 32'(bus.o_saturated), 0);
    chk("s_end_done", 32'(bus.o_run_done), 1);
    chk("s_end_max", 32'(bus.o_max), 15);

    // Max tracking: runs 5, 2, 7, 3 of zeros
    step(1, 0, 1);
    bus.i_mode = 1'b0;
    run_of(5); chk("m_max_a", 32'(bus.o_max), 5); chk("m_last_a", 32'(bus.o_last_len), 5);
    run_of(2); chk("m_max_b", 32'(bus.o_max), 5); chk("m_last_b", 32'(bus.o_last_len), 2);
    for (int k = 1; k <= 7; k++) begin
      step(1, 0, 0);
      if (k >= 6) begin
        chk("m_rec_cur", 32'(bus.o_current), k);
        chk("m_rec_max", 32'(bus.o_max), k);
      end else begin
        chk("m_old_max", 32'(bus.o_max), 5);
      end
    end
    step(1, 1, 0); chk("m_max_c", 32'(bus.o_max), 7); chk("m_last_c", 32'(bus.o_last_len), 7);
    run_of(3); chk("m_max_d", 32'(bus.o_max), 7); chk("m_last_d", 32'(bus.o_last_len), 3);

    // Clear colliding with the terminating mismatch of a 4-run
    step(1, 1, 1);
    for (int k = 0; k < 4; k++) step(1, 0, 0);
    chk("c_cur4", 32'(bus.o_current), 4);
    step(1, 1, 1);
    chk("c_done", 32'(bus.o_run_done), 0);
    chk("c_cur", 32'(bus.o_current), 0);
    chk("c_max", 32'(bus.o_max), 0);
    chk("c_last", 32'(bus.o_last_len), 0);
    chk("c_over", 32'(bus.o_over_count), 0);
    chk("c_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    step(1, 1, 0); chk("c_done_after", 32'(bus.o_run_done), 0);

    // Over-threshold counting: threshold 3, runs 2,3,6,1
    bus.i_threshold = 4'd3;
    step(1, 1, 1);
    run_of(2); chk("v_after2", 32'(bus.o_over_count), 0);
    run_of(3); chk("v_after3", 32'(bus.o_over_count), exp_over1);
    run_of(6); chk("v_after6", 32'(bus.o_over_count), exp_over2);
    run_of(1); chk("v_after1", 32'(bus.o_over_count), exp_over2);
    bus.i_threshold = 4'd0;
    run_of(5); chk("v_thr0", 32'(bus.o_over_count), exp_over2);
    step(1, 1, 1); chk("v_clr", 32'(bus.o_over_count), 0);

    // Reset asserted mid-run
    step(1, 0, 0);
    step(1, 0, 0);
    chk("r_cur2", 32'(bus.o_current), 2);
    #2;
    i_NOT_RESET = 1'b0;
    #1;
    chk("r_cur", 32'(bus.o_current), 0);
    chk("r_max", 32'(bus.o_max), 0);
    chk("r_done", 32'(bus.o_run_done), 0);
    chk("r_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    @(posedge i_clk);
    #1;
    chk("r_done_hold", 32'(bus.o_run_done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
